// File: rtl/seq_detector_param.sv
// Run-time programmable Mealy serial pattern detector with overlap control
// and a saturating match counter.
module seq_detector_param #(
    parameter int                   MAX_LEN     = 8,
    parameter int                   CNT_W       = 16,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 8'b0000_1001,
    parameter int                   DEF_LEN     = 4,
    localparam int                  LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                w_i,
    input  logic                cfg_load_i,
    input  logic [MAX_LEN-1:0]  cfg_pattern_i,
    input  logic [LEN_W-1:0]    cfg_len_i,
    input  logic                cfg_overlap_i,
    input  logic                cnt_clr_i,
    output logic                z_o,
    output logic [CNT_W-1:0]    match_cnt_o,
    output logic                cfg_err_o
);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic               cfgValid;
    logic               fillOk;
    logic               patMatch;

    assign cand     = {hist_q[MAX_LEN-2:0], w_i};
    // Shifting past MAX_LEN yields zero, so len_q == MAX_LEN gives an all-ones mask.
    assign mask     = ~({MAX_LEN{1'b1}} << len_q);
    assign cfgValid = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(MAX_LEN));
    assign fillOk   = (fill_q >= (len_q - LEN_W'(1)));
    assign patMatch = ((cand & mask) == (pattern_q & mask));

    assign z_o         = rst_ni & en_i & ~cfg_load_i & fillOk & patMatch;
    assign match_cnt_o = match_cnt_q;
    assign cfg_err_o   = cfg_err_q;

    always_comb begin
        pattern_d   = pattern_q;
        len_d       = len_q;
        overlap_d   = overlap_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        cfg_err_d   = 1'b0;
        match_cnt_d = match_cnt_q;

        // A load always drops the current bit; a rejected load leaves everything intact.
        if (cfg_load_i) begin
            if (cfgValid) begin
                pattern_d = cfg_pattern_i;
                len_d     = cfg_len_i;
                overlap_d = cfg_overlap_i;
                hist_d    = '0;
                fill_d    = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (en_i) begin
            if (z_o && !overlap_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = cand;
                fill_d = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
            end
        end

        if (cnt_clr_i) begin
            match_cnt_d = '0;
        end else if (z_o && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pattern_q   <= DEF_PATTERN;
            len_q       <= LEN_W'(DEF_LEN);
            overlap_q   <= 1'b1;
            hist_q      <= '0;
            fill_q      <= '0;
            match_cnt_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            overlap_q   <= overlap_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_cnt_q <= match_cnt_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: each driven cycle queues its
// hand-computed expectation, a negedge monitor pops and compares.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef struct {
        bit    expZ;
        int    expCnt;
        int    expErr;
        string name;
    } expect_t;

    logic               clk = 1'b0;
    logic               rstN = 1'b0;
    logic               en = 1'b0;
    logic               w = 1'b0;
    logic               cfgLoad = 1'b0;
    logic [MAX_LEN-1:0] cfgPattern = '0;
    logic [LEN_W-1:0]   cfgLen = '0;
    logic               cfgOverlap = 1'b0;
    logic               cntClr = 1'b0;
    logic               z;
    logic [CNT_W-1:0]   matchCnt;
    logic               cfgErr;

    bit      rstLevel = 1'b0;
    expect_t sb[$];
    int      checks = 0;
    int      errors = 0;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .en_i         (en),
        .w_i          (w),
        .cfg_load_i   (cfgLoad),
        .cfg_pattern_i(cfgPattern),
        .cfg_len_i    (cfgLen),
        .cfg_overlap_i(cfgOverlap),
        .cnt_clr_i    (cntClr),
        .z_o          (z),
        .match_cnt_o  (matchCnt),
        .cfg_err_o    (cfgErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input expect_t e);
        checks++;
        if (z !== e.expZ) begin
            errors++;
            $display("[TB] FAIL %s z: got %b expected %0b", e.name, z, e.expZ);
        end
        if (e.expCnt >= 0) begin
            checks++;
            if (matchCnt !== CNT_W'(e.expCnt)) begin
                errors++;
                $display("[TB] FAIL %s match_cnt: got %0d expected %0d", e.name, matchCnt, e.expCnt);
            end
        end
        if (e.expErr >= 0) begin
            checks++;
            if (cfgErr !== e.expErr[0]) begin
                errors++;
                $display("[TB] FAIL %s cfg_err: got %b expected %0d", e.name, cfgErr, e.expErr);
            end
        end
    endtask

    // Monitor: inputs settle 1 time unit after posedge, outputs are compared on the negedge.
    always @(negedge clk) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    task automatic applyStimulus(input bit enV, input bit wV, input bit loadV,
                                 input logic [MAX_LEN-1:0] patV, input logic [LEN_W-1:0] lenV,
                                 input bit ovlV, input bit clrV,
                                 input bit expZ, input int expCnt, input int expErr,
                                 input string name);
        expect_t e;
        @(posedge clk);
        #1;
        rstN       = rstLevel;
        en         = enV;
        w          = wV;
        cfgLoad    = loadV;
        cfgPattern = patV;
        cfgLen     = lenV;
        cfgOverlap = ovlV;
        cntClr     = clrV;
        e.expZ     = expZ;
        e.expCnt   = expCnt;
        e.expErr   = expErr;
        e.name     = name;
        sb.push_back(e);
    endtask

    task automatic sendBit(input bit wV, input bit expZ, input int expCnt, input string name);
        applyStimulus(1'b1, wV, 1'b0, '0, '0, 1'b0, 1'b0, expZ, expCnt, 0, name);
    endtask

    task automatic idle(input int expCnt, input int expErr, input string name);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, expCnt, expErr, name);
    endtask

    task automatic loadCfg(input logic [MAX_LEN-1:0] patV, input logic [LEN_W-1:0] lenV,
                           input bit ovlV, input bit clrV, input int expCnt, input string name);
        applyStimulus(1'b0, 1'b1, 1'b1, patV, lenV, ovlV, clrV, 1'b0, expCnt, 0, name);
    endtask

    initial begin
        // Reset state
        rstLevel = 1'b0;
        idle(0, 0, "reset0");
        idle(0, 0, "reset1");
        rstLevel = 1'b1;

        // Default pattern 1001
        sendBit(1'b1, 1'b0, 0, "def_b1");
        sendBit(1'b0, 1'b0, 0, "def_b2");
        sendBit(1'b0, 1'b0, 0, "def_b3");
        sendBit(1'b1, 1'b1, 0, "def_b4");
        idle(1, 0, "def_cnt");

        // Pattern 101, overlapping
        loadCfg(8'b101, 4'd3, 1'b1, 1'b1, 1, "ovl_load");
        sendBit(1'b1, 1'b0, 0, "ovl_b1");
        sendBit(1'b0, 1'b0, 0, "ovl_b2");
        sendBit(1'b1, 1'b1, 0, "ovl_b3");
        sendBit(1'b0, 1'b0, 1, "ovl_b4");
        sendBit(1'b1, 1'b1, 1, "ovl_b5");
        idle(2, 0, "ovl_cnt");

        // Pattern 101, non-overlapping
        loadCfg(8'b101, 4'd3, 1'b0, 1'b1, 2, "novl_load");
        sendBit(1'b1, 1'b0, 0, "novl_b1");
        sendBit(1'b0, 1'b0, 0, "novl_b2");
        sendBit(1'b1, 1'b1, 0, "novl_b3");
        sendBit(1'b0, 1'b0, 1, "novl_b4");
        sendBit(1'b1, 1'b0, 1, "novl_b5");
        idle(1, 0, "novl_cnt");

        // Default pattern with two idle cycles after every bit
        loadCfg(8'b0000_1001, 4'd4, 1'b1, 1'b1, 1, "gap_load");
        sendBit(1'b1, 1'b0, 0, "gap_b1");
        idle(0, 0, "gap_i1a");
        idle(0, 0, "gap_i1b");
        sendBit(1'b0, 1'b0, 0, "gap_b2");
        idle(0, 0, "gap_i2a");
        idle(0, 0, "gap_i2b");
        sendBit(1'b0, 1'b0, 0, "gap_b3");
        idle(0, 0, "gap_i3a");
        idle(0, 0, "gap_i3b");
        sendBit(1'b1, 1'b1, 0, "gap_b4");
        idle(1, 0, "gap_i4a");
        idle(1, 0, "gap_i4b");

        // Rejected loads: one-cycle error pulses, config and history kept
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1, 0, "bad0_load");
        idle(1, 1, "bad0_err");
        idle(1, 0, "bad0_clr");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 4'd9, 1'b0, 1'b0, 1'b0, 1, 0, "bad9_load");
        idle(1, 1, "bad9_err");
        idle(1, 0, "bad9_clr");
        sendBit(1'b1, 1'b0, 1, "bad_b1");
        sendBit(1'b0, 1'b0, 1, "bad_b2");
        sendBit(1'b0, 1'b0, 1, "bad_b3");
        sendBit(1'b1, 1'b1, 1, "bad_b4");
        idle(2, 0, "bad_cnt");

        // len=1 pattern '1': every accepted 1 matches; counter saturates at 15
        loadCfg(8'h01, 4'd1, 1'b0, 1'b1, 2, "sat_load");
        for (int i = 0; i < 17; i++) sendBit(1'b1, 1'b1, (i < 15) ? i : 15, "sat_match");
        sendBit(1'b0, 1'b0, 15, "sat_zero");
        applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 15, 0, "clr_with_match");
        idle(0, 0, "clr_cnt");
        sendBit(1'b1, 1'b1, 0, "pre_rst_match");

        // Mid-stream reset discards the partial A5 history and restores 1001
        loadCfg(8'hA5, 4'd8, 1'b0, 1'b0, 1, "a5_load");
        sendBit(1'b1, 1'b0, 1, "a5_b1");
        sendBit(1'b0, 1'b0, 1, "a5_b2");
        sendBit(1'b0, 1'b0, 1, "a5_b3");
        rstLevel = 1'b0;
        idle(0, 0, "mid_rst");
        rstLevel = 1'b1;
        sendBit(1'b1, 1'b0, 0, "post_b1");
        sendBit(1'b0, 1'b0, 0, "post_b2");
        sendBit(1'b0, 1'b0, 0, "post_b3");
        sendBit(1'b1, 1'b1, 0, "post_b4");
        idle(1, 0, "post_cnt");

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
